inst_fetch_rsp: RTL

Instruction-fetch responder between the PC generator and the instruction bus. It accepts a fetch address and chip-enable from the PC stage and runs a single-outstanding req/gnt/rvalid transaction on the instruction bus. It returns the instruction word to the IF/ID boundary, raises a stall request while a fetch is in flight, discards responses made stale by a branch flush, and substitutes a NOP on bus timeout.

---
 rtl/inst_fetch_rsp.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_rsp.sv
// inst_fetch_rsp: instruction-fetch responder between the PC stage and the
// instruction bus. Runs one req/gnt/rvalid transaction at a time, holds the
// fetched word for the IF/ID boundary, drops responses killed by a flush and
// returns NOP_INST with err_o when the bus does not answer within TIMEOUT.
// Optional feature macro: IFETCH_MISALIGN_CHK_EN (reject pc_i[1:0] != 0
// without touching the bus). Without it the low address bits are forced to 0.
module inst_fetch_rsp #(
   parameter logic [7:0]  TIMEOUT  = 8'd255,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        ce_i,
   input  logic        flush_i,
   input  logic        stall_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_gnt_i,
   input  logic        ibus_rvalid_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   output logic        stallreq_o,
   output logic        err_o
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DROP = 3'd3,
      HOLD = 3'd4
   } state_t;

   state_t     state;
   state_t     next_state;
   logic [7:0] tmo_cnt;
   logic       tmo_hit;
   logic       misaligned;
   logic       load_addr;
   logic       cap_data;
   logic       cap_tmo;
   logic       cap_mis;

   // Word-aligned view of a fetch address.
   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

`ifdef IFETCH_MISALIGN_CHK_EN
   assign misaligned = (pc_i[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Counter value reached on this cycle equals TIMEOUT.
   assign tmo_hit = (tmo_cnt == (TIMEOUT - 8'd1));

   // Bus request and valid flag are decoded from the registered state.
   assign ibus_req_o   = (state == REQ);
   assign inst_valid_o = (state == HOLD);
   assign stallreq_o   = (state == REQ) || (state == WAIT) || (state == DROP) ||
                         ((state == IDLE) && ce_i);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode; flush outranks every other event.
   always_comb begin
      next_state = state;
      load_addr  = 1'b0;
      cap_data   = 1'b0;
      cap_tmo    = 1'b0;
      cap_mis    = 1'b0;
      case (state)
         IDLE: begin
            if (flush_i) begin
               next_state = IDLE;
            end else if (ce_i && misaligned) begin
               next_state = HOLD;
               cap_mis    = 1'b1;
            end else if (ce_i) begin
               next_state = REQ;
               load_addr  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         REQ: begin
            if (flush_i) begin
               next_state = ibus_gnt_i ? DROP : IDLE;
            end else if (ibus_gnt_i) begin
               next_state = WAIT;
            end else begin
               next_state = REQ;
            end
         end
         WAIT: begin
            if (flush_i) begin
               next_state = ibus_rvalid_i ? IDLE : DROP;
            end else if (ibus_rvalid_i) begin
               next_state = HOLD;
               cap_data   = 1'b1;
            end else if (tmo_hit) begin
               next_state = HOLD;
               cap_tmo    = 1'b1;
            end else begin
               next_state = WAIT;
            end
         end
         DROP: begin
            if (ibus_rvalid_i || tmo_hit) begin
               next_state = IDLE;
            end else begin
               next_state = DROP;
            end
         end
         HOLD: begin
            if (flush_i) begin
               next_state = IDLE;
            end else if (stall_i) begin
               next_state = HOLD;
            end else if (ce_i && misaligned) begin
               next_state = HOLD;
               cap_mis    = 1'b1;
            end else if (ce_i) begin
               next_state = REQ;
               load_addr  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Response timeout counter: cleared on entry to WAIT/DROP, saturating.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= 8'd0;
      end else if ((next_state != state) && ((next_state == WAIT) || (next_state == DROP))) begin
         tmo_cnt <= 8'd0;
      end else if (((state == WAIT) || (state == DROP)) && (tmo_cnt != 8'hFF)) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end else begin
         tmo_cnt <= tmo_cnt;
      end
   end

   // Bus address and IF/ID output registers; held unless a capture fires.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ibus_addr_o <= 32'd0;
         inst_o      <= NOP_INST;
         inst_addr_o <= 32'd0;
         err_o       <= 1'b0;
      end else begin
         if (load_addr) begin
            ibus_addr_o <= word_addr(pc_i);
         end
         if (cap_data) begin
            inst_o      <= ibus_rdata_i;
            inst_addr_o <= ibus_addr_o;
            err_o       <= 1'b0;
         end else if (cap_tmo) begin
            inst_o      <= NOP_INST;
            inst_addr_o <= ibus_addr_o;
            err_o       <= 1'b1;
         end else if (cap_mis) begin
            inst_o      <= NOP_INST;
            inst_addr_o <= pc_i;
            err_o       <= 1'b1;
         end
      end
   end

endmodule
